// File: rtl/red_pkg.sv
// Shared constants and state encoding for the RED nibble-reduction sequencer.
package red_pkg;

  localparam int RED_W = 16;  // operand / result width
  localparam int NIB_W = 4;   // nibble width
  localparam int NNIB  = 4;   // nibbles per operand
  localparam int ACC_W = 7;   // signed accumulator width, covers -64..+56

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } red_state_e;

  // Sign-extend the accumulator to the full result width.
  function automatic logic [RED_W-1:0] sext_res(input logic [ACC_W-1:0] v);
    return {{(RED_W - ACC_W){v[ACC_W-1]}}, v};
  endfunction

endpackage

// File: rtl/red_nib_add.sv
// Signed add of one nibble from A and one from B, widened to the accumulator width.
module red_nib_add
  import red_pkg::*;
(
  input  logic [NIB_W-1:0] a_nib,
  input  logic [NIB_W-1:0] b_nib,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;

  assign a_ext = {{(ACC_W - NIB_W){a_nib[NIB_W-1]}}, a_nib};
  assign b_ext = {{(ACC_W - NIB_W){b_nib[NIB_W-1]}}, b_nib};
  assign sum   = a_ext + b_ext;

endmodule

// File: rtl/red_seq_ctrl.sv
// RED sequencer: walks the nibble pairs of A and B, NPC pairs per cycle,
// accumulating a signed sum and returning it sign-extended to 16 bits.
module red_seq_ctrl #(
  parameter int NPC  = 1,
  parameter int NNIB = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [red_pkg::RED_W-1:0] A,
  input  logic [red_pkg::RED_W-1:0] B,
  output logic                     busy,
  output logic                     stall,
  output logic                     done,
  output logic [red_pkg::RED_W-1:0] R
);

  localparam int ACC_W = red_pkg::ACC_W;
  localparam int NIB_W = red_pkg::NIB_W;
  localparam logic [2:0] IDX_STEP = 3'(NPC);

  // Reject unsupported build configurations at elaboration.
  if (!(NPC == 1 || NPC == 2 || NPC == 4)) begin : g_bad_npc
    $error("red_seq_ctrl: NPC must be 1, 2 or 4");
  end
  if (NNIB != red_pkg::NNIB) begin : g_bad_nnib
    $error("red_seq_ctrl: NNIB must match red_pkg::NNIB");
  end

  red_pkg::red_state_e state_reg, state_next;

  logic [red_pkg::RED_W-1:0] a_reg, b_reg, r_reg;
  logic [ACC_W-1:0]          acc_reg;
  logic [2:0]                idx_reg;   // 0..4, next nibble pair to consume

  logic                      accept;
  logic                      last_pair;
  logic [ACC_W-1:0]          nib_sum [NPC];
  logic [ACC_W-1:0]          partial;
  logic [ACC_W-1:0]          acc_sum;

  // One adder per nibble pair handled in a cycle; pair gi is at idx_reg + gi.
  for (genvar gi = 0; gi < NPC; gi++) begin : g_nib
    logic [1:0] nib_idx;
    assign nib_idx = idx_reg[1:0] + 2'(gi);
    red_nib_add u_add (
      .a_nib (a_reg[{nib_idx, 2'b00} +: NIB_W]),
      .b_nib (b_reg[{nib_idx, 2'b00} +: NIB_W]),
      .sum   (nib_sum[gi])
    );
  end

  // Sum this cycle's pair results and fold them into the running total.
  always_comb begin
    partial = '0;
    for (int i = 0; i < NPC; i++) begin
      partial = partial + nib_sum[i];
    end
    acc_sum = acc_reg + partial;
  end

  assign last_pair = ((idx_reg + IDX_STEP) == 3'd4);

  // Next-state and status decode.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      red_pkg::IDLE: begin
        accept = 1'b1;
        if (start) state_next = red_pkg::ACCUM;
      end
      red_pkg::ACCUM: begin
        busy = 1'b1;
        if (last_pair) state_next = red_pkg::DONE;
      end
      red_pkg::DONE: begin
        done   = 1'b1;
        accept = 1'b1;
        state_next = start ? red_pkg::ACCUM : red_pkg::IDLE;
      end
      default: state_next = red_pkg::IDLE;
    endcase
  end

  assign stall = (start & accept) | busy;
  assign R     = r_reg;

  // State, operand capture, accumulation and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= red_pkg::IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && start) begin
        a_reg   <= A;
        b_reg   <= B;
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (state_reg == red_pkg::ACCUM) begin
        acc_reg <= acc_sum;
        idx_reg <= idx_reg + IDX_STEP;
        if (last_pair) r_reg <= red_pkg::sext_res(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Directed self-checking bench for red_seq_ctrl.
module tb_red_seq_ctrl;

  localparam int NPC = 1;
  localparam int LAT = 4 / NPC;   // ACCUM cycles per operation

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, stall, done;
  logic [15:0] R;

  int checks = 0;
  int errors = 0;

  red_seq_ctrl #(.NPC(NPC), .NNIB(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .R     (R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until done is seen; cyc counts negedges since acceptance.
  task automatic wait_done(inout int cyc, output int busy_cnt);
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // One complete operation with a single-cycle start pulse.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int cyc, bc;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; A = 16'h5A5A; B = 16'hA5A5;
    cyc = 1;
    wait_done(cyc, bc);
    chk({tag, "_latency"}, 32'(cyc), 32'(LAT + 1));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(LAT));
    chk({tag, "_R"}, 32'(R), 32'(exp));
    $display("op %s A=%h B=%h R=%h exp=%h cycles=%0d", tag, a, b, R, exp, cyc);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_R_hold"}, 32'(R), 32'(exp));
  endtask

  initial begin
    int cyc, bc, stall_low, pulses;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_op("v1234", 16'h1234, 16'h1111, 16'h000E);
    run_op("vF000", 16'hF000, 16'h0F00, 16'hFFFE);
    run_op("vABCD", 16'hABCD, 16'h1234, 16'hFFF8);
    run_op("vFFFF", 16'hFFFF, 16'hFFFF, 16'hFFF8);
    run_op("v7777", 16'h7777, 16'h7777, 16'h0038);
    run_op("v8888", 16'h8888, 16'h8888, 16'hFFC0);

    // Start held high; A disturbed mid-accumulation; back-to-back second op.
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    stall_low = 0;
    #1 if (stall !== 1'b1) stall_low++;
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == ((LAT >= 2) ? 2 : 1)) A = 16'h0000;
      #1 if (stall !== 1'b1) stall_low++;
      @(negedge clk);
      cyc++;
    end
    chk("held_latency", 32'(cyc), 32'(LAT + 1));
    chk("held_R_first", 32'(R), 32'h000E);
    A = 16'h0001; B = 16'h0001;
    #1 if (stall !== 1'b1) stall_low++;
    chk("held_busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    bc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bc++;
      if (stall !== 1'b1) stall_low++;
      @(negedge clk);
      cyc++;
    end
    chk("b2b_gap", 32'(cyc), 32'(LAT));
    chk("b2b_busy", 32'(bc), 32'(LAT));
    chk("b2b_R", 32'(R), 32'h0002);
    chk("b2b_stall_continuous", 32'(stall_low), 32'd0);
    $display("op b2b A=0001 B=0001 R=%h exp=0002 gap=%0d stall_low=%0d", R, cyc, stall_low);
    @(negedge clk);

    // Abort with reset in the second ACCUM cycle (first for single-cycle builds).
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (LAT >= 2) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    pulses = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    $display("op abort R=%h done_pulses=%0d", R, pulses);

    run_op("after_abort", 16'hABCD, 16'h1234, 16'hFFF8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
